// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared defaults and write-source encodings for reg_file_sb
package reg_file_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 3;

  localparam logic W_SEL_ALU = 1'b0;
  localparam logic W_SEL_ID  = 1'b1;
endpackage

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - per-register busy flags; reserve beats writeback clear
module reg_file_scoreboard import reg_file_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit R0_ZERO = 1'b0,
  localparam int NREGS  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_enable,
  input  logic [ADDR_W-1:0] res_addr,
  input  logic              w_enable,
  input  logic [ADDR_W-1:0] w_addr,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy_nxt;

  // A reserve landing with a writeback means a new producer is pending, so set wins.
  always_comb begin
    busy_nxt = busy_vec;
    for (int i = 0; i < NREGS; i++) begin
      if (res_enable && res_addr == ADDR_W'(i))
        busy_nxt[i] = 1'b1;
      else if (w_enable && w_addr == ADDR_W'(i))
        busy_nxt[i] = 1'b0;
    end
    if (R0_ZERO)
      busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy_vec <= '0;
    else
      busy_vec <= busy_nxt;
  end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - 2R/1W register file with write-first bypass and busy scoreboard
module reg_file_sb import reg_file_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit R0_ZERO = 1'b0,
  localparam int NREGS  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] r_addr_0,
  input  logic [ADDR_W-1:0] r_addr_1,
  output logic [DATA_W-1:0] r_val_0,
  output logic [DATA_W-1:0] r_val_1,
  output logic              r_busy_0,
  output logic              r_busy_1,
  input  logic              w_enable,
  input  logic              w_select,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_alu,
  input  logic [DATA_W-1:0] w_id,
  input  logic              res_enable,
  input  logic [ADDR_W-1:0] res_addr,
  output logic [NREGS-1:0]  busy_vec
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] wd;
  logic              w_store;

  assign wd      = (w_select == W_SEL_ID) ? w_id : w_alu;
  assign w_store = w_enable && !(R0_ZERO && w_addr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (w_store) begin
      regs[w_addr] <= wd;
    end
  end

  // Hard-wired zero overrides the bypass as well as the array.
  always_comb begin
    r_val_0 = regs[r_addr_0];
    r_val_1 = regs[r_addr_1];
    if (w_enable && r_addr_0 == w_addr)
      r_val_0 = wd;
    if (w_enable && r_addr_1 == w_addr)
      r_val_1 = wd;
    if (R0_ZERO && r_addr_0 == '0)
      r_val_0 = '0;
    if (R0_ZERO && r_addr_1 == '0)
      r_val_1 = '0;
  end

  // A writeback in the same cycle lifts the stall, matching the bypassed data.
  assign r_busy_0 = busy_vec[r_addr_0] & ~(w_enable && w_addr == r_addr_0);
  assign r_busy_1 = busy_vec[r_addr_1] & ~(w_enable && w_addr == r_addr_1);

  reg_file_scoreboard #(
    .ADDR_W  (ADDR_W),
    .R0_ZERO (R0_ZERO)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .res_enable (res_enable),
    .res_addr   (res_addr),
    .w_enable   (w_enable),
    .w_addr     (w_addr),
    .busy_vec   (busy_vec)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - vector table with expected-result queue for reg_file_sb
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  r_addr_0, r_addr_1, w_addr, res_addr;
  logic        w_enable, w_select, res_enable;
  logic [31:0] w_alu, w_id;
  logic [31:0] r_val_0, r_val_1, z_val_0, z_val_1;
  logic        r_busy_0, r_busy_1, z_busy_0, z_busy_1;
  logic [7:0]  busy_vec, z_busy_vec;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        we, wsel;
    logic [2:0]  waddr;
    logic [31:0] walu, wid;
    logic        re;
    logic [2:0]  raddr, ra0, ra1;
    logic [31:0] v0, v1;
    logic        b0, b1;
    logic [7:0]  bv;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  reg_file_sb dut (
    .clk(clk), .rst(rst), .r_addr_0(r_addr_0), .r_addr_1(r_addr_1),
    .r_val_0(r_val_0), .r_val_1(r_val_1), .r_busy_0(r_busy_0), .r_busy_1(r_busy_1),
    .w_enable(w_enable), .w_select(w_select), .w_addr(w_addr), .w_alu(w_alu),
    .w_id(w_id), .res_enable(res_enable), .res_addr(res_addr), .busy_vec(busy_vec)
  );

  reg_file_sb #(.R0_ZERO(1'b1)) dut_z (
    .clk(clk), .rst(rst), .r_addr_0(r_addr_0), .r_addr_1(r_addr_1),
    .r_val_0(z_val_0), .r_val_1(z_val_1), .r_busy_0(z_busy_0), .r_busy_1(z_busy_1),
    .w_enable(w_enable), .w_select(w_select), .w_addr(w_addr), .w_alu(w_alu),
    .w_id(w_id), .res_enable(res_enable), .res_addr(res_addr), .busy_vec(z_busy_vec)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic we, input logic wsel, input logic [2:0] waddr,
                              input logic [31:0] walu, input logic [31:0] wid,
                              input logic re, input logic [2:0] raddr,
                              input logic [2:0] ra0, input logic [2:0] ra1,
                              input logic [31:0] v0, input logic [31:0] v1,
                              input logic b0, input logic b1, input logic [7:0] bv);
    vec_t v;
    v.we = we; v.wsel = wsel; v.waddr = waddr; v.walu = walu; v.wid = wid;
    v.re = re; v.raddr = raddr; v.ra0 = ra0; v.ra1 = ra1;
    v.v0 = v0; v.v1 = v1; v.b0 = b0; v.b1 = b1; v.bv = bv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    w_enable = v.we; w_select = v.wsel; w_addr = v.waddr; w_alu = v.walu; w_id = v.wid;
    res_enable = v.re; res_addr = v.raddr; r_addr_0 = v.ra0; r_addr_1 = v.ra1;
  endtask

  task automatic idle();
    w_enable = 1'b0; w_select = 1'b0; w_addr = '0; w_alu = '0; w_id = '0;
    res_enable = 1'b0; res_addr = '0;
  endtask

  initial begin
    vec_t e;
    idle();
    r_addr_0 = '0; r_addr_1 = '0;

    // Reset then read every register
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0,0,0,0,0, 0,0, 3'(i), 3'(7-i), 0,0, 0,0, 8'h00));
    vecs.push_back(mk(1,0,3,32'hDEADBEEF,0,      0,0, 3,0, 32'hDEADBEEF,0,            0,0, 8'h00));
    vecs.push_back(mk(0,0,0,0,0,                  0,0, 3,3, 32'hDEADBEEF,32'hDEADBEEF, 0,0, 8'h00));
    vecs.push_back(mk(1,1,5,32'hFFFFFFFF,32'h1234,0,0, 5,3, 32'h1234,32'hDEADBEEF,     0,0, 8'h00));
    vecs.push_back(mk(0,0,0,0,0,                  0,0, 5,5, 32'h1234,32'h1234,         0,0, 8'h00));
    vecs.push_back(mk(0,0,0,0,0,                  1,6, 0,6, 0,0,                       0,0, 8'h40));
    vecs.push_back(mk(0,0,0,0,0,                  0,0, 5,6, 32'h1234,0,                0,1, 8'h40));
    vecs.push_back(mk(1,0,6,32'hCAFE0006,0,       0,0, 6,6, 32'hCAFE0006,32'hCAFE0006, 0,0, 8'h00));
    vecs.push_back(mk(0,0,0,0,0,                  0,0, 6,3, 32'hCAFE0006,32'hDEADBEEF, 0,0, 8'h00));
    vecs.push_back(mk(1,0,2,32'h55,0,             1,2, 2,2, 32'h55,32'h55,             0,0, 8'h04));
    vecs.push_back(mk(0,0,0,0,0,                  0,0, 2,2, 32'h55,32'h55,             1,1, 8'h04));
    vecs.push_back(mk(0,0,0,0,0,                  1,2, 2,4, 32'h55,0,                  1,0, 8'h04));
    vecs.push_back(mk(1,0,4,32'h44,0,             0,0, 4,2, 32'h44,32'h55,             0,1, 8'h04));
    vecs.push_back(mk(1,0,2,32'h66,0,             0,0, 2,4, 32'h66,32'h44,             0,0, 8'h00));
    vecs.push_back(mk(1,0,0,32'h77,0,             1,0, 0,4, 32'h77,32'h44,             0,0, 8'h01));
    vecs.push_back(mk(0,0,0,0,0,                  0,0, 0,2, 32'h77,32'h66,             1,0, 8'h01));

    #1 rst = 1'b1;
    #2;
    chk("reset busy_vec", 32'(busy_vec), 32'h0);
    chk("reset r_val_0", r_val_0, 32'h0);
    chk("reset z_busy_vec", 32'(z_busy_vec), 32'h0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      #2;
      e = exp_q.pop_front();
      chk($sformatf("v%0d r_val_0", i), r_val_0, e.v0);
      chk($sformatf("v%0d r_val_1", i), r_val_1, e.v1);
      chk($sformatf("v%0d r_busy_0", i), 32'(r_busy_0), 32'(e.b0));
      chk($sformatf("v%0d r_busy_1", i), 32'(r_busy_1), 32'(e.b1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d busy_vec", i), 32'(busy_vec), 32'(e.bv));
    end

    // Async reset between edges after reserving 1 and 4 and writing 7
    @(negedge clk);
    idle(); w_enable = 1'b1; w_addr = 3'd7; w_alu = 32'hA5; res_enable = 1'b1; res_addr = 3'd1;
    @(negedge clk);
    idle(); res_enable = 1'b1; res_addr = 3'd4;
    @(posedge clk); #1;
    chk("pre-rst busy_vec", 32'(busy_vec), 32'h13);
    @(negedge clk);
    idle(); r_addr_0 = 3'd7; r_addr_1 = 3'd1;
    #1;
    chk("pre-rst r_val_0", r_val_0, 32'hA5);
    chk("pre-rst r_busy_1", 32'(r_busy_1), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("async busy_vec", 32'(busy_vec), 32'h0);
    chk("async r_val_0", r_val_0, 32'h0);
    chk("async r_busy_1", 32'(r_busy_1), 32'h0);
    #1 rst = 1'b0;

    // First write after reset release
    @(negedge clk);
    w_enable = 1'b1; w_addr = 3'd1; w_alu = 32'h11;
    @(negedge clk);
    idle(); r_addr_0 = 3'd1;
    #1;
    chk("post-rst write", r_val_0, 32'h11);

    // R0_ZERO instance: write and reserve register 0
    @(negedge clk);
    w_enable = 1'b1; w_addr = 3'd0; w_alu = 32'h77; res_enable = 1'b1; res_addr = 3'd0;
    r_addr_0 = 3'd0; r_addr_1 = 3'd0;
    #2;
    chk("r0z bypass r_val_0", z_val_0, 32'h0);
    chk("r0z r_busy_0", 32'(z_busy_0), 32'h0);
    chk("plain r0 bypass", r_val_0, 32'h77);
    @(posedge clk); #1;
    chk("r0z busy_vec", 32'(z_busy_vec), 32'h0);
    chk("plain r0 busy_vec", 32'(busy_vec), 32'h01);
    @(negedge clk);
    idle();
    #2;
    chk("r0z r_val_1", z_val_1, 32'h0);
    chk("plain r0 stored", r_val_1, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
